// File: rtl/mac_4bit_seq_if.sv
// mac_4bit_seq_if
// Pair-stream and result handshake bundle between fabric logic and the
// MAC sequencer.
//   s_valid/s_ready/s_oper/s_coef          : operand/coefficient pairs in
//   result_valid/result_ready/result_data  : captured 4-bit MAC result out
// master = fabric side, slave = sequencer side.
interface mac_4bit_seq_if;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_oper;
    logic [3:0] s_coef;
    logic       result_valid;
    logic       result_ready;
    logic [3:0] result_data;

    modport master (
        output s_valid, s_oper, s_coef, result_ready,
        input  s_ready, result_valid, result_data
    );

    modport slave (
        input  s_valid, s_oper, s_coef, result_ready,
        output s_ready, result_valid, result_data
    );
endinterface

// File: rtl/mac_4bit_seq.sv
// mac_4bit_seq
// Initiator-side sequencer for the 4-bit eFPGA math-unit MAC. Latches a job
// config on start, streams pairs into the MAC, waits one settle cycle, then
// captures MAC_OUT[3:0] and returns it over a valid/ready handshake.
// Ports:
//   MAC_ACC_CLK, acc_ff_rstn : clock and async active-low reset shared with the MAC
//   start, cfg_*             : job request and configuration (sampled on accept)
//   busy                     : job in flight
//   bus (slave)              : pair stream in, result out
//   mac_*                    : MAC control/data pins; mac_out is the MAC result
// Optional: define MAC_SEQ_ABORT_EN to add the abort input.
//
// state | meaning
// IDLE  | waiting for start with nonzero length
// RUN   | accepting pairs, clocking the MAC on each beat
// DRAIN | one settle cycle for accumulator and registered out_sel
// DONE  | result held until result_ready
module mac_4bit_seq #(
    parameter int LEN_W = 8
) (
    input  logic             MAC_ACC_CLK,
    input  logic             acc_ff_rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [5:0]       cfg_out_sel,
    input  logic             cfg_tc,
    input  logic             cfg_sat,
    input  logic             cfg_rnd,
    output logic             busy,
`ifdef MAC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    mac_4bit_seq_if.slave    bus,
    output logic [3:0]       mac_oper_data,
    output logic [3:0]       mac_coef_data,
    output logic             mac_clk_en,
    output logic             mac_acc_clear,
    output logic             mac_acc_rnd,
    output logic             mac_acc_sat,
    output logic [5:0]       mac_out_sel,
    output logic             mac_tc,
    input  logic [4:0]       mac_out
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] cnt;
    logic             first;
    logic [5:0]       sel_q;
    logic             tc_q, sat_q, rnd_q;
    logic [3:0]       result_q;
    logic             abort_i;
    logic             accept_start;
    logic             capture;
    logic             mac_out_unused;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // MAC_OUT[4] carries no information for a 4-bit result.
    assign mac_out_unused = mac_out[4];

    assign accept_start = (state == IDLE) && start && (cfg_len != '0);
    assign capture      = (state == DRAIN) && !abort_i;

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            first    <= 1'b0;
            sel_q    <= '0;
            tc_q     <= 1'b0;
            sat_q    <= 1'b0;
            rnd_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            if (accept_start) begin
                cnt   <= cfg_len;
                first <= 1'b1;
                sel_q <= cfg_out_sel;
                tc_q  <= cfg_tc;
                sat_q <= cfg_sat;
                rnd_q <= cfg_rnd;
            end else if (mac_clk_en) begin
                cnt   <= cnt - LEN_W'(1);
                first <= 1'b0;
            end
            if (capture) begin
                result_q <= mac_out[3:0];
            end
        end
    end

    always_comb begin
        state_nx      = state;
        bus.s_ready   = 1'b0;
        mac_clk_en    = 1'b0;
        mac_acc_clear = 1'b0;
        mac_acc_rnd   = 1'b0;
        case (state)
            IDLE: begin
                if (accept_start) state_nx = RUN;
            end
            RUN: begin
                if (abort_i) begin
                    state_nx = IDLE;
                end else begin
                    bus.s_ready = 1'b1;
                    if (bus.s_valid) begin
                        mac_clk_en = 1'b1;
                        // The first beat either clears or seeds the accumulator.
                        mac_acc_clear = first && !rnd_q;
                        mac_acc_rnd   = first && rnd_q;
                        if (cnt == LEN_W'(1)) state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nx = abort_i ? IDLE : DONE;
            end
            DONE: begin
                if (bus.result_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy             = (state != IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.result_data  = result_q;
    assign mac_oper_data    = bus.s_oper;
    assign mac_coef_data    = bus.s_coef;
    assign mac_out_sel      = sel_q;
    assign mac_tc           = tc_q;
    assign mac_acc_sat      = sat_q;
endmodule
